// File: rtl/decode_stage.sv
// decode_stage: registered instruction-decode stage with a register-busy
// scoreboard. It sits between fetch and execute.
//
// It splits each instruction into op/f1/f2/f3 fields. IMM_OP_MASK classifies
// the opcode as R-type or I-type. Issue stalls on RAW/WAW hazards against the
// busy vector until the matching writeback arrives.
//
// Optional feature, selected by the macro DECODE_WB_BYPASS_EN:
//   defined   - a writeback in the current cycle masks its busy bit in the
//               hazard check, so a dependent instruction issues in that cycle.
//   undefined - the hazard check sees only the registered busy vector, so a
//               dependent instruction waits one cycle after its writeback.
//
// Handshake: a transfer happens on a port when valid and ready are both high
// at the rising clock edge. Upstream accept is in_valid & in_ready. Downstream
// consume is out_valid & out_ready. While out_valid is high and out_ready is
// low, every out_* field holds its value.

module decode_stage #(
  parameter int                    OP_W        = 4,
  parameter int                    REG_W       = 4,
  parameter int                    INSTR_W     = 16,  // must equal OP_W + 3*REG_W
  parameter logic [2**OP_W-1:0]    IMM_OP_MASK = 16'h01E0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [INSTR_W-1:0]   in_instr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OP_W-1:0]      out_op,
  output logic [REG_W-1:0]     out_rs1,
  output logic [REG_W-1:0]     out_rs2,
  output logic [REG_W-1:0]     out_rd,
  output logic [REG_W-1:0]     out_imm,
  output logic                 out_reg_imm,
  input  logic                 wb_valid,
  input  logic [REG_W-1:0]     wb_reg,
  input  logic                 flush,
  output logic [2**REG_W-1:0]  busy
);

  localparam int NREG = 2**REG_W;

  // Raw instruction fields. The opcode is at the MSB end, followed by f1, f2, f3.
  logic [OP_W-1:0]  w_op;
  logic [REG_W-1:0] w_f1;
  logic [REG_W-1:0] w_f2;
  logic [REG_W-1:0] w_f3;

  // Decoded view of the incoming instruction.
  logic             w_is_imm;
  logic [REG_W-1:0] w_rs2;
  logic [REG_W-1:0] w_rd;
  logic [REG_W-1:0] w_imm;

  // Scoreboard and handshake nets.
  logic [NREG-1:0]  w_wb_onehot;
  logic [NREG-1:0]  w_busy_chk;
  logic [NREG-1:0]  w_busy_nxt;
  logic             w_hazard;
  logic             w_in_ready;
  logic             w_accept;

  // Registered state.
  logic [NREG-1:0]  r_busy;
  logic             r_out_valid;
  logic [OP_W-1:0]  r_out_op;
  logic [REG_W-1:0] r_out_rs1;
  logic [REG_W-1:0] r_out_rs2;
  logic [REG_W-1:0] r_out_rd;
  logic [REG_W-1:0] r_out_imm;
  logic             r_out_reg_imm;

  assign w_op = in_instr[OP_W+3*REG_W-1 -: OP_W];
  assign w_f1 = in_instr[3*REG_W-1 -: REG_W];
  assign w_f2 = in_instr[2*REG_W-1 -: REG_W];
  assign w_f3 = in_instr[REG_W-1:0];

  // I-type instructions reuse f2 as the destination and f3 as the immediate.
  // They have no second source operand.
  assign w_is_imm = IMM_OP_MASK[w_op];
  assign w_rs2    = w_is_imm ? '0   : w_f2;
  assign w_rd     = w_is_imm ? w_f2 : w_f3;
  assign w_imm    = w_is_imm ? w_f3 : '0;

  // One-hot mask of the register being written back this cycle (zero if none).
  always_comb begin
    w_wb_onehot = '0;
    if (wb_valid) begin
      w_wb_onehot[wb_reg] = 1'b1;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  // A writeback in this cycle already frees its register for the hazard check.
  assign w_busy_chk = r_busy & ~w_wb_onehot;
`else
  // Only registered busy state counts, so a dependent instruction issues one cycle after its writeback.
  assign w_busy_chk = r_busy;
`endif

  // The hazard check covers every field that names a register: sources for RAW, destination for WAW.
  // For I-type, f2 is the destination and f3 is an immediate, so f3 is ignored.
  assign w_hazard = w_busy_chk[w_f1] | w_busy_chk[w_f2] |
                    (!w_is_imm & w_busy_chk[w_f3]);

  // The stage accepts when the output slot is free or draining this cycle.
  // Reset, flush and hazards block acceptance.
  assign w_in_ready = !reset & !flush & !w_hazard & (!r_out_valid | out_ready);
  assign w_accept   = in_valid & w_in_ready;

  // Next busy vector. Clears (writeback, flushed entry) are applied first and the new destination is set last.
  // A set/clear collision on the same register therefore leaves the bit set, owned by the new instruction.
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_onehot;
    if (flush && r_out_valid) begin
      w_busy_nxt[r_out_rd] = 1'b0;
    end
    if (w_accept) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
  end

  // Output register and scoreboard update. Flush beats both accept and consume.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy        <= '0;
      r_out_valid   <= 1'b0;
      r_out_op      <= '0;
      r_out_rs1     <= '0;
      r_out_rs2     <= '0;
      r_out_rd      <= '0;
      r_out_imm     <= '0;
      r_out_reg_imm <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid   <= 1'b1;
        r_out_op      <= w_op;
        r_out_rs1     <= w_f1;
        r_out_rs2     <= w_rs2;
        r_out_rd      <= w_rd;
        r_out_imm     <= w_imm;
        r_out_reg_imm <= w_is_imm;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready    = w_in_ready;
  assign out_valid   = r_out_valid;
  assign out_op      = r_out_op;
  assign out_rs1     = r_out_rs1;
  assign out_rs2     = r_out_rs2;
  assign out_rd      = r_out_rd;
  assign out_imm     = r_out_imm;
  assign out_reg_imm = r_out_reg_imm;
  assign busy        = r_busy;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage. The driver issues directed instructions and pushes each hand-decoded expected entry.
// The monitor pops and compares an entry on every output transfer.
// The bench follows DECODE_WB_BYPASS_EN when that macro is defined for the build.

module tb_decode_stage;

  localparam int W = 21;  // {op, rs1, rs2, rd, imm, reg_imm}

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [3:0]  out_rd;
  logic [3:0]  out_imm;
  logic        out_reg_imm;
  logic        wb_valid;
  logic [3:0]  wb_reg;
  logic        flush;
  logic [15:0] busy;

  logic [W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  decode_stage dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_op      (out_op),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_rd      (out_rd),
    .out_imm     (out_imm),
    .out_reg_imm (out_reg_imm),
    .wb_valid    (wb_valid),
    .wb_reg      (wb_reg),
    .flush       (flush),
    .busy        (busy)
  );

  // Clock and timeout watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] pk(input logic [3:0] op, input logic [3:0] rs1,
                                      input logic [3:0] rs2, input logic [3:0] rd,
                                      input logic [3:0] imm, input logic ri);
    return {op, rs1, rs2, rd, imm, ri};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  // Advance to just after the next rising edge (the drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction, wait (bounded) for in_ready, then transfer it on the next edge.
  task automatic send(input logic [15:0] instr, input logic [W-1:0] exp, input bit push);
    int cnt;
    cnt = 0;
    in_instr = instr;
    in_valid = 1'b1;
    #1;
    while (!in_ready && cnt < 20) begin
      @(posedge clk);
      #2;
      cnt++;
    end
    chk("send_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready && push) exp_q.push_back(exp);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wb(input logic [3:0] r);
    wb_valid = 1'b1;
    wb_reg   = r;
    tick();
    wb_valid = 1'b0;
  endtask

  // Scoreboard monitor: compares every output transfer against the queue head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready && !flush) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got op=%0h rs1=%0h rd=%0h required no transfer",
                 out_op, out_rs1, out_rd);
      end else begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        e = exp_q.pop_front();
        a = {out_op, out_rs1, out_rs2, out_rd, out_imm, out_reg_imm};
        if (a !== e) begin
          n_err++;
          $display("FAIL out_entry: got op/rs1/rs2/rd/imm/ri=%h/%h/%h/%h/%h/%b required %h/%h/%h/%h/%h/%b",
                   a[20:17], a[16:13], a[12:9], a[8:5], a[4:1], a[0],
                   e[20:17], e[16:13], e[12:9], e[8:5], e[4:1], e[0]);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    n_vec = 0; n_err = 0;
    reset = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {16'd0, busy}, 32'd0);
    chk("rst_fields", {11'd0, out_op, out_rs1, out_rs2, out_rd, out_imm, out_reg_imm}, 32'd0);
    reset = 1'b0;

    // Single R-type: op1 rs1=2 rs2=3 rd=4.
    send(16'h1234, pk(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b0), 1'b1);
    #1;
    chk("r_busy4", {16'd0, busy}, 32'h0010);
    chk("r_out_valid", {31'd0, out_valid}, 32'd1);

    // I-type: op5 rs1=A rd=3 imm=7.
    send(16'h5A37, pk(4'h5, 4'hA, 4'h0, 4'h3, 4'h7, 1'b1), 1'b1);
    #1;
    chk("i_busy", {16'd0, busy}, 32'h0018);
    wb(4'h4);
    wb(4'h3);
    #1;
    chk("wb_clear", {16'd0, busy}, 32'h0000);

    // RAW stall: 2450 reads r4 written by 1234.
    send(16'h1234, pk(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b0), 1'b1);
    in_instr = 16'h2450;
    in_valid = 1'b1;
    #1;
    chk("raw_stall0", {31'd0, in_ready}, 32'd0);
    tick();
    #1;
    chk("raw_stall1", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1;
    wb_reg   = 4'h4;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("raw_bypass_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h2, 4'h4, 4'h5, 4'h0, 4'h0, 1'b0));
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
`else
    chk("raw_wb_cycle_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("raw_after_wb_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h2, 4'h4, 4'h5, 4'h0, 4'h0, 1'b0));
    tick();
    in_valid = 1'b0;
`endif
    #1;
    chk("raw_busy", {16'd0, busy}, 32'h0001);
    wb(4'h0);

    // Backpressure: hold 3120 for three cycles, then stream two more.
    out_ready = 1'b0;
    send(16'h3120, pk(4'h3, 4'h1, 4'h2, 4'h0, 4'h0, 1'b0), 1'b1);
    in_instr = 16'h4567;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_hold", {16'd0, out_op, out_rs1, out_rs2, out_rd}, 32'h3120);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 1'b0));
    tick();
    in_instr = 16'h4891;
    #1;
    chk("bp_stream_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h4, 4'h8, 4'h9, 4'h1, 4'h0, 1'b0));
    tick();
    in_valid = 1'b0;
    #1;
    chk("bp_busy", {16'd0, busy}, 32'h0083);
    wb(4'h0);
    wb(4'h7);
    wb(4'h1);
    #1;
    chk("bp_busy_clear", {16'd0, busy}, 32'h0000);

    // Flush a held entry with rd=4.
    out_ready = 1'b0;
    send(16'h1234, '0, 1'b0);
    in_instr = 16'h6120;
    in_valid = 1'b1;
    flush    = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_busy", {16'd0, busy}, 32'h0000);
    out_ready = 1'b1;
    #1;
    chk("post_flush_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h6, 4'h1, 4'h0, 4'h2, 4'h0, 1'b1));
    tick();
    in_valid = 1'b0;
    #1;
    chk("post_flush_busy", {16'd0, busy}, 32'h0004);
    wb(4'h2);

    // Set/clear collision on r4: 7149 is I-type with rd=4.
    send(16'h1234, pk(4'h1, 4'h2, 4'h3, 4'h4, 4'h0, 1'b0), 1'b1);
    in_instr = 16'h7149;
    in_valid = 1'b1;
    #1;
    chk("waw_stall", {31'd0, in_ready}, 32'd0);
    wb_valid = 1'b1;
    wb_reg   = 4'h4;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    chk("coll_ready", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h7, 4'h1, 4'h0, 4'h4, 4'h9, 1'b1));
    tick();
    wb_valid = 1'b0;
    in_valid = 1'b0;
`else
    chk("coll_wb_cycle_ready", {31'd0, in_ready}, 32'd0);
    tick();
    wb_valid = 1'b0;
    #1;
    chk("coll_busy_cleared", {16'd0, busy}, 32'h0000);
    chk("coll_ready_late", {31'd0, in_ready}, 32'd1);
    exp_q.push_back(pk(4'h7, 4'h1, 4'h0, 4'h4, 4'h9, 1'b1));
    tick();
    in_valid = 1'b0;
`endif
    #1;
    chk("coll_busy", {16'd0, busy}, 32'h0010);

    // Writeback to a register that is not busy.
    wb(4'h9);
    #1;
    chk("stray_wb_busy", {16'd0, busy}, 32'h0010);

    // Reset mid-operation with a held entry.
    out_ready = 1'b0;
    send(16'h2560, '0, 1'b0);
    #1;
    chk("pre_reset_busy", {16'd0, busy}, 32'h0011);
    reset = 1'b1;
    #1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    #1;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_busy", {16'd0, busy}, 32'h0000);
    chk("mid_rst_fields", {11'd0, out_op, out_rs1, out_rs2, out_rd, out_imm, out_reg_imm}, 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage with valid/ready handshakes and a register-busy scoreboard. Splits each instruction into opcode, source, destination and immediate fields, classifies it as R- or I-type through a parameter mask, and stalls issue on RAW/WAW hazards until the matching writeback arrives. Sits between instruction fetch and the execute/ALU stage.

## Interface

Parameters:
- `OP_W`, 4: opcode field width.
- `REG_W`, 4: register-index / immediate field width; register file has `2**REG_W` entries.
- `INSTR_W`, 16: instruction width; must equal `OP_W + 3*REG_W`.
- `IMM_OP_MASK`, 16'h01E0: bit n set means opcode n is I-type; width `2**OP_W`. The default makes opcodes 5–8 I-type.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: fetch presents an instruction.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in INSTR_W: instruction. Fields from MSB down: op, f1, f2, f3.
- `out_valid` out 1: decoded entry valid.
- `out_ready` in 1: execute consumes the entry.
- `out_op` out OP_W: opcode.
- `out_rs1` out REG_W: source 1. Always f1.
- `out_rs2` out REG_W: source 2. f2 for R-type; 0 for I-type.
- `out_rd` out REG_W: destination. f3 for R-type; f2 for I-type.
- `out_imm` out REG_W: immediate. f3 for I-type; 0 for R-type.
- `out_reg_imm` out 1: 1 = I-type.
- `wb_valid` in 1: writeback completes.
- `wb_reg` in REG_W: register written back.
- `flush` in 1: kill the held entry.
- `busy` out 2**REG_W: scoreboard vector.

## Operation

- **Classification:** I-type = `IMM_OP_MASK[op]`.
- **Hazard on the incoming instruction:**
  - R-type: `busy[f1] | busy[f2] | busy[f3]`.
  - I-type: `busy[f1] | busy[f2]`.
- **Ready:** `in_ready = !reset & !flush & !hazard & (!out_valid | out_ready)`.
- **Accept** (`in_valid & in_ready`):
  - Decoded fields are registered and `out_valid` is set.
  - `busy[rd]` is set.
- **Consume:** `out_valid & out_ready` with no new accept clears `out_valid`.
- **Writeback:** `wb_valid` clears `busy[wb_reg]` at the clock edge.
- **Same register set and cleared in one cycle:** set wins. The new instruction owns the register.
- **Flush:**
  - `out_valid` goes to 0.
  - `busy[out_rd]` of the killed entry is cleared, if `out_valid` was 1.
  - No accept occurs that cycle.
  - Flush has priority over `out_ready`.
- **Writeback with no matching busy bit:** ignored. The bit stays 0.
- **Output stability:** outputs hold while `out_valid & !out_ready`.

## Timing

- **Latency:** accept at edge N, so `out_*` is valid after edge N. One cycle of latency.
- **Throughput:** one instruction per cycle when `out_ready` is held high and there are no hazards.
- **Combinational path:** `in_ready` depends combinationally on `out_ready`, `flush`, `busy` and `in_instr`.
- **Hazard release:** without bypass, a writeback at edge N clears `busy`, and a dependent instruction is accepted at edge N+1 at the earliest.
- **Reset values:** `out_valid=0`, all `out_*` fields 0, `busy=0`, `in_ready=0` while `reset` is high.
- **Reset mid-operation:** the held entry is discarded and all busy bits are cleared.

## Configuration

`DECODE_WB_BYPASS_EN`:
- **Defined:** the hazard check masks `busy[wb_reg]` when `wb_valid` is high in the same cycle. A dependent instruction is accepted in the same cycle as its writeback, at edge N. If both events target the same register, the accepted instruction still sets that busy bit (set wins).
- **Undefined:** the hazard check uses only the registered `busy`, giving the one-cycle penalty described under Timing.

## Test plan

- **Reset then single R-type:** `in_instr=16'h1234`, `out_ready=1` → next cycle `out_op=1`, `rs1=2`, `rs2=3`, `rd=4`, `imm=0`, `reg_imm=0`, `busy[4]=1`.
- **I-type decode:** `16'h5A37` → `out_op=5`, `rs1=10`, `rd=3`, `imm=7`, `rs2=0`, `reg_imm=1`, `busy[3]=1`.
- **RAW stall:** `16'h1234` then `16'h2450` → `in_ready=0` until `wb_valid=1, wb_reg=4`.
  - Without bypass, the second instruction is accepted one cycle after the writeback.
  - With `DECODE_WB_BYPASS_EN`, it is accepted in the writeback cycle.
- **Backpressure:** `out_ready=0` for 3 cycles with `in_valid=1` → `in_ready=0`, outputs stable. Raising `out_ready` yields one transfer per cycle.
- **Flush:** held entry with `rd=4`, assert `flush` → `out_valid=0`, `busy[4]=0`, no accept that cycle.
- **Set/clear collision:** `busy[4]=1`; `wb_reg=4` writeback in the same cycle as accepting an instruction with `rd=4`. This only reaches accept with `DECODE_WB_BYPASS_EN` defined, since the bypass masks the WAW hazard. → `busy[4]` remains 1.
